// File: rtl/board_pkg.sv
// Shared constants for the board RAM arbiter and display renderer.
// Grant FSM encodings and board cell encodings live here.
package board_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int BOARD_BASE = 62;
  localparam int CELLS      = 64;
  localparam int STARVE_MAX = 4;
  localparam int IDX_W      = 6;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CPU_DONE  = 2'd1;
  localparam logic [1:0] ST_DISP_DONE = 2'd2;

  localparam logic [DATA_W-1:0] CELL_MINE     = 8'd60;
  localparam logic [DATA_W-1:0] CELL_FLAG     = 8'd32;
  localparam logic [DATA_W-1:0] CELL_QUESTION = 8'd63;
  localparam int                CELL_REVEAL_BIT = 7;

  // RAM address of a board cell given its row and column.
  function automatic logic [ADDR_W-1:0] cell_addr(
    input logic [1:0] row,
    input logic [3:0] col
  );
    return ADDR_W'(BOARD_BASE) + ADDR_W'({row, col});
  endfunction

endpackage

// File: rtl/board_scan_ctr.sv
// Display scan position and busy flag.
// Advances once per delivered cell; drops busy after the last one.
module board_scan_ctr
  import board_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             advance,
  output logic             busy,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign busy = busy_q;
  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(CELLS - 1));

  // Start a scan when idle; step or finish while busy.
  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    if (!busy_q && start) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end else if (busy_q && advance) begin
      if (last) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Shares the board RAM between CPU load/store and the display scan.
// CPU wins unless the display has been starved STARVE_MAX cycles.
module board_mem_arbiter
  import board_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_start,
  output logic              disp_busy,
  output logic              disp_valid,
  output logic [IDX_W-1:0]  disp_index,
  output logic [DATA_W-1:0] disp_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             hold_q;
  logic             scan_busy, scan_last;
  logic [IDX_W-1:0] scan_idx;
  logic             gate, cpu_elig, disp_pend;
  logic             cpu_gnt, disp_gnt;

  board_scan_ctr u_scan (
    .clk     (CLK),
    .rst     (RESET),
    .start   (disp_start),
    .advance (disp_valid),
    .busy    (scan_busy),
    .idx     (scan_idx),
    .last    (scan_last)
  );

  // Pick at most one RAM client; no grants in or just after reset.
  always_comb begin
    gate      = !RESET && !hold_q;
    cpu_elig  = cpu_req && (state_q != ST_CPU_DONE);
    disp_pend = scan_busy && (state_q != ST_DISP_DONE);
    cpu_gnt   = gate && cpu_elig &&
                (!disp_pend || (starve_q < SW'(STARVE_MAX)));
    disp_gnt  = gate && !cpu_gnt && disp_pend;
  end

  // Drive the RAM port and present last cycle's read data.
  always_comb begin
    ram_en     = cpu_gnt || disp_gnt;
    ram_we     = cpu_gnt && cpu_we;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (disp_gnt) begin
      ram_addr  = ADDR_W'(BOARD_BASE) + ADDR_W'(scan_idx);
    end
    cpu_ready  = (state_q == ST_CPU_DONE);
    cpu_rdata  = cpu_ready ? ram_rdata : '0;
    disp_valid = (state_q == ST_DISP_DONE);
    disp_index = scan_idx;
    disp_data  = disp_valid ? ram_rdata : '0;
    disp_busy  = scan_busy && !(disp_valid && scan_last);
  end

  // Next grant state and display starvation count.
  always_comb begin
    state_d = ST_IDLE;
    if (cpu_gnt) begin
      state_d = ST_CPU_DONE;
    end else if (disp_gnt) begin
      state_d = ST_DISP_DONE;
    end
    starve_d = starve_q;
    if (!scan_busy || disp_gnt) begin
      starve_d = '0;
    end else if (disp_pend && (starve_q < SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Arbiter state registers; hold_q masks the first cycle out of reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      hold_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural RAM.
// CPU and display results are scoreboarded and checked on negedges.
module tb_board_mem_arbiter;
  import board_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              disp_start = 1'b0;
  logic              disp_busy;
  logic              disp_valid;
  logic [IDX_W-1:0]  disp_index;
  logic [DATA_W-1:0] disp_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  board_mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .disp_start(disp_start), .disp_busy(disp_busy),
    .disp_valid(disp_valid), .disp_index(disp_index),
    .disp_data(disp_data),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  logic [7:0] ram [256];
  logic [7:0] exp_mem [256];

  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  typedef struct {
    bit         we;
    logic [7:0] data;
  } cpu_exp_t;

  cpu_exp_t cpu_q[$];
  int       disp_q[$];
  int       n_checks = 0;
  int       n_pass = 0;
  int       n_valid = 0;
  int       n_ready = 0;
  int       gap = 0;
  int       de;
  cpu_exp_t ce;
  logic [7:0] cell5_seen = 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Display scoreboard plus starvation gap tracking.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (disp_valid) begin
        n_valid++;
        check("starve_gap", 32'(gap <= STARVE_MAX + 2), 1);
        if (disp_q.size() == 0) begin
          check("disp_extra_valid", 1, 0);
        end else begin
          de = disp_q.pop_front();
          check("disp_index", 32'(disp_index), de);
          check("disp_data", 32'(disp_data), 32'(exp_mem[BOARD_BASE + de]));
          check("disp_busy_at_valid", 32'(disp_busy),
                (de == CELLS - 1) ? 0 : 1);
          if (de == 5) cell5_seen = disp_data;
        end
      end
      if (disp_valid || !disp_busy) gap = 0;
      else gap++;
    end
  end

  // CPU scoreboard: every cpu_ready must match one issued access.
  always @(negedge CLK) begin
    if (!RESET && cpu_ready) begin
      n_ready++;
      if (cpu_q.size() == 0) begin
        check("cpu_dup_ready", 1, 0);
      end else begin
        ce = cpu_q.pop_front();
        if (!ce.we) check("cpu_rdata", 32'(cpu_rdata), 32'(ce.data));
      end
    end
  end

  task automatic cpu_op(input bit we, input logic [7:0] a,
                        input logic [7:0] d, input bit keep);
    cpu_exp_t x;
    bit got;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    x.we = we;
    x.data = we ? d : exp_mem[a];
    if (we) exp_mem[a] = d;
    cpu_q.push_back(x);
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge CLK);
      got = cpu_ready;
    end
    if (!got) check("cpu_timeout", 0, 1);
    @(posedge CLK); #1;
    if (!keep) cpu_req = 1'b0;
  endtask

  task automatic start_scan();
    disp_start = 1'b1;
    for (int i = 0; i < CELLS; i++) disp_q.push_back(i);
    @(posedge CLK); #1;
    disp_start = 1'b0;
  endtask

  task automatic wait_scan_done(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge CLK);
      done = !disp_busy && (disp_q.size() == 0);
    end
    check(tag, 32'(done), 1);
    @(posedge CLK); #1;
  endtask

  task automatic wait_index(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge CLK);
      hit = disp_valid && (disp_index == IDX_W'(target));
    end
    check("wait_index", 32'(hit), 1);
  endtask

  initial begin
    int waits;
    int r0;
    for (int i = 0; i < 256; i++) begin
      ram[i] <= 8'(i * 7 + 3);
      exp_mem[i] = 8'(i * 7 + 3);
    end

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_cpu_ready", 32'(cpu_ready), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_disp_busy", 32'(disp_busy), 0);
    check("rst_disp_valid", 32'(disp_valid), 0);
    check("rst_disp_index", 32'(disp_index), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 8'h40; cpu_wdata = 8'h3C;
    exp_mem[8'h40] = 8'h3C;
    cpu_q.push_back('{1'b1, 8'h3C});
    @(negedge CLK);
    check("st_ram_en", 32'(ram_en), 1);
    check("st_ram_we", 32'(ram_we), 1);
    check("st_ram_addr", 32'(ram_addr), 32'h40);
    check("st_ram_wdata", 32'(ram_wdata), 32'h3C);
    check("st_ready_early", 32'(cpu_ready), 0);
    @(negedge CLK);
    check("st_ready", 32'(cpu_ready), 1);
    @(posedge CLK); #1;
    cpu_we = 1'b0;
    cpu_q.push_back('{1'b0, 8'h3C});
    @(negedge CLK);
    check("ld_ram_en", 32'(ram_en), 1);
    check("ld_ram_we", 32'(ram_we), 0);
    @(negedge CLK);
    check("ld_ready", 32'(cpu_ready), 1);
    check("ld_rdata", 32'(cpu_rdata), 32'h3C);
    @(posedge CLK); #1;
    cpu_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    start_scan();
    for (int i = 0; i < CELLS; i++) begin
      waits = 0;
      do begin
        @(negedge CLK);
        waits++;
      end while (!ram_en && waits < 8);
      check("scan_addr", 32'(ram_addr), 32'(8'(BOARD_BASE + i)));
      check("scan_we", 32'(ram_we), 0);
      check("scan_spacing", waits, 1);
      @(negedge CLK);
      check("scan_valid", 32'(disp_valid), 1);
    end
    wait_scan_done("scan_plain_done");

    r0 = n_ready;
    start_scan();
    for (int k = 0; k < 40; k++) begin
      cpu_op(1'b0, 8'(k * 5), 8'h00, k != 39);
    end
    wait_scan_done("scan_contended_done");
    check("cpu_ready_count", n_ready - r0, 40);

    r0 = n_valid;
    start_scan();
    wait_index(10);
    @(posedge CLK); #1;
    disp_start = 1'b1;
    @(posedge CLK); #1;
    disp_start = 1'b0;
    wait_scan_done("scan_restart_ignored");
    check("valid_count", n_valid - r0, CELLS);

    start_scan();
    cpu_op(1'b1, 8'(BOARD_BASE + 5), 8'hA5, 1'b0);
    wait_scan_done("scan_cell5_done");
    check("cell5_new", 32'(cell5_seen), 32'hA5);

    start_scan();
    wait_index(20);
    @(posedge CLK); #1;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 8'h50; cpu_wdata = 8'h77;
    #2;
    RESET = 1'b1;
    cpu_q.delete();
    disp_q.delete();
    #1;
    check("arst_ram_en", 32'(ram_en), 0);
    check("arst_ram_we", 32'(ram_we), 0);
    check("arst_disp_busy", 32'(disp_busy), 0);
    check("arst_disp_valid", 32'(disp_valid), 0);
    check("arst_cpu_ready", 32'(cpu_ready), 0);
    check("arst_disp_index", 32'(disp_index), 0);
    repeat (2) begin
      @(negedge CLK);
      check("arst_hold_we", 32'(ram_we), 0);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_we", 32'(ram_we), 0);
    check("post_rst_en", 32'(ram_en), 0);
    @(posedge CLK); #1;
    cpu_req = 1'b0;
    check("no_write_0x50", 32'(ram[8'h50]), 32'(exp_mem[8'h50]));

    start_scan();
    waits = 0;
    do begin
      @(negedge CLK);
      waits++;
    end while (!ram_en && waits < 8);
    check("rescan_addr0", 32'(ram_addr), BOARD_BASE);
    wait_scan_done("rescan_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
